// File: rtl/tff_toggle_scheduler.sv
// Round-robin scheduler that lends one shared toggle flop to N requesters.
// Each grant is a non-preemptive burst of exactly req_len toggles.
module tff_toggle_scheduler #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            clear_n,
    input  logic [N-1:0]    req,
    input  logic [N*CW-1:0] req_len,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic            busy,
    output logic            t_en,
    output logic [CW-1:0]   toggles_left,
    output logic            q,
    output logic            qbar
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [N-1:0]  gnt_nx;
    logic [N-1:0]  done_nx;
    logic          busy_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          q_nx;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nx;
    logic [PW-1:0] win;
    logic [PW-1:0] win_nx;

    logic          found;
    logic [PW-1:0] pick;
    logic [PW-1:0] cand;
    logic [N-1:0]  pick_oh;
    logic [CW-1:0] pick_len;

    // Search starts at ptr and wraps, so the last winner has lowest priority
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = PW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        pick_oh  = '0;
        pick_len = '0;
        for (int i = 0; i < N; i++) begin
            if (pick == PW'(i)) begin
                pick_oh[i] = 1'b1;
                pick_len   = req_len[i*CW +: CW];
            end
        end
    end

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        done_nx  = done;
        busy_nx  = busy;
        cnt_nx   = cnt;
        q_nx     = q;
        ptr_nx   = ptr;
        win_nx   = win;
        unique case (state)
            IDLE: begin
                if (found) begin
                    busy_nx = 1'b1;
                    cnt_nx  = pick_len;
                    win_nx  = pick;
                    if (pick_len != '0) begin
                        gnt_nx   = pick_oh;
                        state_nx = BURST;
                    end else begin
                        done_nx  = pick_oh;
                        state_nx = DONE;
                    end
                end
            end
            BURST: begin
                q_nx   = ~q;
                cnt_nx = cnt - CW'(1);
                // gnt still holds onehot(win) here, so it doubles as done
                if (cnt == CW'(1)) begin
                    gnt_nx   = '0;
                    done_nx  = gnt;
                    state_nx = DONE;
                end
            end
            DONE: begin
                done_nx  = '0;
                busy_nx  = 1'b0;
                ptr_nx   = (win == PW'(N - 1)) ? '0 : win + PW'(1);
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
            q     <= 1'b0;
            ptr   <= '0;
            win   <= '0;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            done  <= done_nx;
            busy  <= busy_nx;
            cnt   <= cnt_nx;
            q     <= q_nx;
            ptr   <= ptr_nx;
            win   <= win_nx;
        end
    end

    assign t_en         = (state == BURST);
    assign toggles_left = cnt;
    assign qbar         = ~q;

endmodule

// File: tb/tb_tff_toggle_scheduler.sv
// Directed bench for tff_toggle_scheduler (N=4, CW=8).
// Inputs change and outputs are sampled on the falling edge.
module tb_tff_toggle_scheduler;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic [3:0]  req = 4'b0;
    logic [31:0] req_len = 32'h0;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        t_en;
    logic [7:0]  toggles_left;
    logic        q;
    logic        qbar;

    int total = 0;
    int bad = 0;

    tff_toggle_scheduler #(.N(4), .CW(8)) dut (
        .clk          (clk),
        .clear_n      (clear_n),
        .req          (req),
        .req_len      (req_len),
        .gnt          (gnt),
        .done         (done),
        .busy         (busy),
        .t_en         (t_en),
        .toggles_left (toggles_left),
        .q            (q),
        .qbar         (qbar)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int rr_order [5];
        rr_order = '{3, 0, 1, 2, 3};

        // reset state
        cyc();
        cyc();
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_qbar", 32'(qbar), 32'h1);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_tl", 32'(toggles_left), 32'h0);
        chk("rst_ten", 32'(t_en), 32'h0);
        clear_n = 1'b1;
        cyc();
        chk("idle_busy", 32'(busy), 32'h0);

        // single burst of 3 from q=0, ptr=0
        req = 4'b0001;
        req_len = 32'h0000_0003;
        cyc();
        chk("s_gnt", 32'(gnt), 32'h1);
        chk("s_busy", 32'(busy), 32'h1);
        chk("s_tl3", 32'(toggles_left), 32'h3);
        chk("s_ten", 32'(t_en), 32'h1);
        chk("s_q0", 32'(q), 32'h0);
        req = 4'b0000;
        cyc();
        chk("s_q1", 32'(q), 32'h1);
        chk("s_tl2", 32'(toggles_left), 32'h2);
        chk("s_gnt2", 32'(gnt), 32'h1);
        cyc();
        chk("s_q2", 32'(q), 32'h0);
        chk("s_tl1", 32'(toggles_left), 32'h1);
        cyc();
        chk("s_qend", 32'(q), 32'h1);
        chk("s_qbar", 32'(qbar), 32'h0);
        chk("s_done", 32'(done), 32'h1);
        chk("s_gnt0", 32'(gnt), 32'h0);
        chk("s_busyd", 32'(busy), 32'h1);
        chk("s_tend", 32'(t_en), 32'h0);
        chk("s_tl0", 32'(toggles_left), 32'h0);
        cyc();
        chk("s_done0", 32'(done), 32'h0);
        chk("s_busy0", 32'(busy), 32'h0);

        // zero-length from ptr=1: requester 2 wins, no toggle
        req = 4'b0100;
        req_len = 32'h0000_0000;
        cyc();
        chk("z_done", 32'(done), 32'h4);
        chk("z_gnt", 32'(gnt), 32'h0);
        chk("z_busy", 32'(busy), 32'h1);
        chk("z_q", 32'(q), 32'h1);
        chk("z_ten", 32'(t_en), 32'h0);
        req = 4'b0000;
        cyc();
        chk("z_done0", 32'(done), 32'h0);
        chk("z_busy0", 32'(busy), 32'h0);
        chk("z_qhold", 32'(q), 32'h1);

        // round robin from ptr=3, all len=1, q starts at 1
        req = 4'b1111;
        req_len = 32'h0101_0101;
        for (int b = 0; b < 5; b++) begin
            cyc();
            chk($sformatf("rr_gnt%0d", b), 32'(gnt),
                32'h1 << rr_order[b]);
            chk($sformatf("rr_tl%0d", b), 32'(toggles_left), 32'h1);
            cyc();
            chk($sformatf("rr_done%0d", b), 32'(done),
                32'h1 << rr_order[b]);
            chk($sformatf("rr_gnt0_%0d", b), 32'(gnt), 32'h0);
            cyc();
            chk($sformatf("rr_idle%0d", b), 32'(busy), 32'h0);
            if (b == 4) req = 4'b0000;
        end
        chk("rr_q", 32'(q), 32'h0);

        // non-preemption: ptr=0, q=0, requester 1 len 5
        req = 4'b0010;
        req_len = 32'h0000_0500;
        cyc();
        chk("np_gnt", 32'(gnt), 32'h2);
        chk("np_tl5", 32'(toggles_left), 32'h5);
        cyc();
        cyc();
        chk("np_q2", 32'(q), 32'h0);
        chk("np_tl3", 32'(toggles_left), 32'h3);
        req = 4'b0100;
        req_len = 32'h0002_0100;
        cyc();
        chk("np_hold", 32'(gnt), 32'h2);
        chk("np_tl2", 32'(toggles_left), 32'h2);
        cyc();
        cyc();
        chk("np_done", 32'(done), 32'h2);
        chk("np_q5", 32'(q), 32'h1);
        cyc();
        chk("np_gap", 32'(gnt), 32'h0);
        cyc();
        chk("np_gnt2", 32'(gnt), 32'h4);
        chk("np_tl2b", 32'(toggles_left), 32'h2);
        req = 4'b0000;
        cyc();
        cyc();
        chk("np_done2", 32'(done), 32'h4);
        chk("np_qend", 32'(q), 32'h1);
        cyc();

        // max length from ptr=3, q=1: requester 0 wins
        req = 4'b0001;
        req_len = 32'h0000_00FF;
        cyc();
        chk("mx_gnt", 32'(gnt), 32'h1);
        chk("mx_tl", 32'(toggles_left), 32'hFF);
        req = 4'b0000;
        for (int i = 1; i <= 255; i++) begin
            cyc();
            chk($sformatf("mx_tl_%0d", i), 32'(toggles_left),
                32'(255 - i));
            chk($sformatf("mx_q_%0d", i), 32'(q),
                (i % 2 == 1) ? 32'h0 : 32'h1);
        end
        chk("mx_done", 32'(done), 32'h1);
        chk("mx_gnt0", 32'(gnt), 32'h0);
        cyc();
        chk("mx_busy0", 32'(busy), 32'h0);

        // reset mid-burst from ptr=1, q=0: requester 0 wins
        req = 4'b0001;
        req_len = 32'h0000_0004;
        cyc();
        chk("ar_gnt", 32'(gnt), 32'h1);
        cyc();
        chk("ar_q1", 32'(q), 32'h1);
        #2;
        clear_n = 1'b0;
        req = 4'b0000;
        #1;
        chk("ar_q", 32'(q), 32'h0);
        chk("ar_qbar", 32'(qbar), 32'h1);
        chk("ar_gnt0", 32'(gnt), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_tl", 32'(toggles_left), 32'h0);
        chk("ar_ten", 32'(t_en), 32'h0);
        cyc();
        clear_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("ar_nodone%0d", i), 32'(done), 32'h0);
            chk($sformatf("ar_idle%0d", i), 32'(busy), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
